// File: rtl/bcd_pkg.sv
// Shared BCD types, the per-cycle operation decode and a digit-validity helper used by the
// field counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned MaxDigits = 8;
  localparam int unsigned MaxW      = 4 * MaxDigits;

  // Operation chosen for one cycle after strobe priority is resolved.
  typedef enum logic [2:0] {
    OpIdle,
    OpLoad,
    OpInc,
    OpDec,
    OpCount
  } op_e;

  // Callers zero-extend narrower fields; zero nibbles are legal BCD.
  function automatic logic bcd_valid(input logic [MaxW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(MaxDigits); i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit step: adds or subtracts the incoming carry/borrow and reports ripple out.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t q,
  output logic       cout
);

  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= 4'd9) begin
          q    = 4'd0;
          cout = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          q    = 4'd9;
          cout = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_field_counter.sv
// Multi-digit BCD field counter with runtime limits, edit pulses, parallel load and registered
// carry/load-error pulses. Instances cascade through carry_out -> en.
module bcd_field_counter
  import bcd_pkg::*;
#(
  parameter int unsigned             DIGITS  = 2,
  parameter logic [4*DIGITS-1:0]     RST_VAL = '0,
  parameter bit                      WRAP    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                inc,
  input  logic                dec,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] min_val,
  input  logic [4*DIGITS-1:0] max_val,
  output logic [4*DIGITS-1:0] value,
  output logic                carry_out,
  output logic                load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]  value_q, value_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic [W-1:0]  up_v, dn_v;
  logic [DIGITS:0] up_c, dn_c;
  logic          at_max, at_min, load_ok;
  op_e           op;

  assign up_c[0] = 1'b1;
  assign dn_c[0] = 1'b1;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_digit
    bcd_digit u_up (
      .d    (value_q[4*g +: 4]),
      .up   (1'b1),
      .cin  (up_c[g]),
      .q    (up_v[4*g +: 4]),
      .cout (up_c[g+1])
    );
    bcd_digit u_dn (
      .d    (value_q[4*g +: 4]),
      .up   (1'b0),
      .cin  (dn_c[g]),
      .q    (dn_v[4*g +: 4]),
      .cout (dn_c[g+1])
    );
  end

  // A ripple out of the top digit means all-nines (or all-zeros), which is always at the limit.
  assign at_max  = (value_q >= max_val) || up_c[DIGITS];
  assign at_min  = (value_q <= min_val) || dn_c[DIGITS];
  assign load_ok = bcd_valid(MaxW'(load_val)) && (load_val >= min_val) && (load_val <= max_val);

  always_comb begin
    op = OpIdle;
    if (load) begin
      op = OpLoad;
    end else if (inc || dec) begin
      // Both edit strobes together cancel and still block en.
      if (inc && !dec) op = OpInc;
      else if (dec && !inc) op = OpDec;
    end else if (en) begin
      op = OpCount;
    end
  end

  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    unique case (op)
      OpIdle: ;
      OpLoad: begin
        if (load_ok) value_d = load_val;
        else err_d = 1'b1;
      end
      OpInc: value_d = at_max ? (WRAP ? min_val : max_val) : up_v;
      OpDec: begin
        if (at_min) value_d = WRAP ? max_val : min_val;
        else if (value_q > max_val) value_d = max_val;
        else value_d = dn_v;
      end
      OpCount: begin
        if (at_max) begin
          value_d = WRAP ? min_val : max_val;
          carry_d = WRAP;
        end else begin
          value_d = up_v;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= RST_VAL;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_q;
  assign load_err  = err_q;

endmodule
